mux_4x_nbit1: RTL and testbench
===============================

MUX_4X_NBIT1 -- requirements
Module: mux_4x_nbit1

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter BUS_WIDTH, default 8: data bus width; legal range 1 to 64.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  capture enable for the registered output path.
REQ-006 a, b, c, d  input  BUS_WIDTH each  data inputs 0..3.
REQ-007 sel  input  2  select: 0=a, 1=b, 2=c, 3=d.
REQ-008 y  output  BUS_WIDTH  combinational mux output.
REQ-009 y_q  output  BUS_WIDTH  registered mux output.
REQ-010 sel_q  output  2  sel value captured with y_q.
REQ-011 y_vld  output  1  high for the cycle after an en capture.

Function
REQ-012 y SHALL equal the input chosen by sel in the same delta, with zero clock latency and no latch.
REQ-013 All four sel codes SHALL be fully decoded, with no default or don't-care branch.
REQ-014 A change on any data input or on sel SHALL propagate to y without a clock edge.
REQ-015 At a rising clk edge with en=1, y_q SHALL load y and sel_q SHALL load sel.
REQ-016 With en=0, y_q and sel_q SHALL hold their values.
REQ-017 y_vld SHALL be a registered copy of en, giving 1-cycle latency; consecutive en cycles give consecutive y_vld cycles.
REQ-018 No arithmetic is performed; data SHALL pass bit-exact at the full BUS_WIDTH, with no extension or truncation.
REQ-019 If sel and data change in the same cycle as a capture, the values present before the edge SHALL be captured.

Reset
REQ-020 While rst_n=0, the following SHALL hold immediately, independent of clk: y_q=0, sel_q=0, y_vld=0.
REQ-021 y SHALL remain purely combinational and SHALL be unaffected by rst_n.
REQ-022 Reset asserted mid-operation SHALL discard any capture in progress; reset deassertion SHALL take effect only at the next rising edge.

Configuration
REQ-023 Macro MUX4_PARITY_EN SHALL control the parity feature.
- Defined: add output y_par (1 bit), the registered even parity (XOR-reduce) of the value loaded into y_q. y_par updates with y_q and resets to 0.
- Undefined: port y_par and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Shared package mux4_pkg SHALL hold:
- select constants SEL_A=0, SEL_B=1, SEL_C=2, SEL_D=3;
- a 2-bit sel typedef;
- default width constant DEF_BUS_WIDTH=8.
REQ-025 The combinational selector SHALL be the sub-module mux4_sel (parameter BUS_WIDTH), instantiated once.
REQ-026 The registers and optional parity SHALL reside in mux_4x_nbit1.

Verification
REQ-027 BUS_WIDTH=8, a=0x11, b=0x22, c=0x33, d=0x44, sweep sel 0..3 with no clock -> y=0x11, 0x22, 0x33, 0x44 respectively.
REQ-028 sel=2, c changes 0x33->0xA5 mid-cycle -> y=0xA5 immediately; y_q unchanged until the next en edge.
REQ-029 en=1 for one edge with sel=3, d=0x44 -> next cycle y_q=0x44, sel_q=3, y_vld=1; the following cycle with en=0 -> y_vld=0, y_q holds 0x44.
REQ-030 rst_n driven low between clock edges with y_q=0x44 -> y_q=0, sel_q=0, y_vld=0 at once; y still tracks its inputs.
REQ-031 MUX4_PARITY_EN defined, capture 0x07 -> y_par=1; capture 0x03 -> y_par=0.
REQ-032 Five cycles of random a..d with sel=i[1:0] for i=0..4, en=1 -> each cycle y_q equals the previous cycle's selected input.

Source files
------------

// File: rtl/mux4_pkg.sv
// Shared select codes, select type and default width for the 4:1 mux.
package mux4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'd0;
    localparam sel_t SEL_B = 2'd1;
    localparam sel_t SEL_C = 2'd2;
    localparam sel_t SEL_D = 2'd3;

    localparam int DEF_BUS_WIDTH = 8;

endpackage

// File: rtl/mux4_sel.sv
// Purely combinational 4:1 selector, all four codes decoded explicitly.
module mux4_sel
    import mux4_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  sel_t                 sel,
    output logic [BUS_WIDTH-1:0] y
);

    always_comb begin
        unique case (sel)
            SEL_A: y = a;
            SEL_B: y = b;
            SEL_C: y = c;
            SEL_D: y = d;
        endcase
    end

endmodule

// File: rtl/mux_4x_nbit1.sv
// 4:1 mux with combinational and enable-captured outputs.
// Optional registered parity output y_par when MUX4_PARITY_EN is defined.
module mux_4x_nbit1
    import mux4_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  sel_t                 sel,
    output logic [BUS_WIDTH-1:0] y,
    output logic [BUS_WIDTH-1:0] y_q,
    output sel_t                 sel_q,
`ifdef MUX4_PARITY_EN
    output logic                 y_par,
`endif
    output logic                 y_vld
);

    mux4_sel #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_sel (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(sel),
        .y  (y)
    );

    // y_vld follows en unconditionally; data/sel only load on en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= SEL_A;
            y_vld <= 1'b0;
`ifdef MUX4_PARITY_EN
            y_par <= 1'b0;
`endif
        end else begin
            y_vld <= en;
            if (en) begin
                y_q   <= y;
                sel_q <= sel;
`ifdef MUX4_PARITY_EN
                y_par <= ^y;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_4x_nbit1.sv
// Randomized bench for mux_4x_nbit1 against a behavioural model.
module tb_mux_4x_nbit1;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   sel;
    logic [W-1:0] y, y_q;
    logic [1:0]   sel_q;
    logic         y_vld;
`ifdef MUX4_PARITY_EN
    logic         y_par;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    logic [W-1:0] m_q   = '0;
    logic [1:0]   m_sel = '0;
    logic         m_vld = 1'b0;
    logic         m_par = 1'b0;

    mux_4x_nbit1 #(
        .BUS_WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .sel  (sel),
        .y    (y),
        .y_q  (y_q),
        .sel_q(sel_q),
`ifdef MUX4_PARITY_EN
        .y_par(y_par),
`endif
        .y_vld(y_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pick(input logic [1:0] s);
        logic [W-1:0] arr [4];
        arr = '{a, b, c, d};
        return arr[s];
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: capture on edge, async clear
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   = '0;
            m_sel = '0;
            m_vld = 1'b0;
            m_par = 1'b0;
        end else begin
            m_vld = en;
            if (en) begin
                m_q   = pick(sel);
                m_sel = sel;
                m_par = ^m_q;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("y", 64'(y), 64'(pick(sel)));
            chk("y_q", 64'(y_q), 64'(m_q));
            chk("sel_q", 64'(sel_q), 64'(m_sel));
            chk("y_vld", 64'(y_vld), 64'(m_vld));
`ifdef MUX4_PARITY_EN
            chk("y_par", 64'(y_par), 64'(m_par));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [W-1:0] exp27 [4];
        logic [W-1:0] expq;
        exp27 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b1;
        en = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        sel = 2'd0;
        #1 rst_n = 1'b0;
        chk_on = 1;
        #1;
        chk("rst y_q", 64'(y_q), 64'h0);
        chk("rst sel_q", 64'(sel_q), 64'h0);
        chk("rst y_vld", 64'(y_vld), 64'h0);
        a = 8'h5A;
        #1 chk("rst y comb", 64'(y), 64'h5A);
        repeat (2) tick();
        rst_n = 1'b1;

        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1 chk("sweep y", 64'(y), 64'(exp27[s]));
        end

        tick();
        sel = 2'd2;
        #1 c = 8'hA5;
        #1 chk("c change y", 64'(y), 64'hA5);
        chk("c change y_q", 64'(y_q), 64'h0);

        tick();
        c = 8'h33;
        sel = 2'd3;
        en = 1'b1;
        tick();
        en = 1'b0;
        #1;
        chk("cap y_q", 64'(y_q), 64'h44);
        chk("cap sel_q", 64'(sel_q), 64'h3);
        chk("cap y_vld", 64'(y_vld), 64'h1);
        tick();
        chk("hold y_vld", 64'(y_vld), 64'h0);
        chk("hold y_q", 64'(y_q), 64'h44);

        #1 rst_n = 1'b0;
        #1;
        chk("async y_q", 64'(y_q), 64'h0);
        chk("async sel_q", 64'(sel_q), 64'h0);
        chk("async y_vld", 64'(y_vld), 64'h0);
        sel = 2'd0;
        a = 8'h77;
        #1 chk("async y comb", 64'(y), 64'h77);
        tick();
        rst_n = 1'b1;

`ifdef MUX4_PARITY_EN
        a = 8'h07; sel = 2'd0; en = 1'b1;
        tick();
        en = 1'b0;
        chk("par 07", 64'(y_par), 64'h1);
        a = 8'h03; en = 1'b1;
        tick();
        en = 1'b0;
        chk("par 03", 64'(y_par), 64'h0);
`endif

        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom);
            c = W'($urandom); d = W'($urandom);
            sel = 2'(i);
            en = 1'b1;
            expq = pick(sel);
            tick();
            chk("seq y_q", 64'(y_q), 64'(expq));
        end
        en = 1'b0;

        repeat (400) begin
            a = W'($urandom); b = W'($urandom);
            c = W'($urandom); d = W'($urandom);
            sel = 2'($urandom);
            en = 1'($urandom);
            if (!rst_n)
                rst_n = 1'b1;
            else if ($urandom_range(0, 15) == 0)
                rst_n = 1'b0;
            tick();
        end
        rst_n = 1'b1;
        tick();
        chk_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
